rmii_tx_frame_loader: RTL and testbench
=======================================

// Module: rmii_tx_frame_loader
// PURPOSE
//  Write-side sequencer for the RMII TX byte FIFO. Arbitrates round-robin between two frame
//  sources, streams the granted frame (dest MAC onward, no preamble/SFD) into the FIFO, pads
//  it to MIN_LEN, computes and appends the Ethernet FCS, and flags the final byte with EOD.
//  Feeds the FIFO that the RMII TX PHY interface drains; that interface adds the preamble.
// PARAMETERS
//  MIN_LEN  60    min bytes before FCS; zero-pad up to this (0 disables padding)
//  MAX_LEN  1514  max source bytes accepted per frame; excess is drained and discarded
// PORTS
//  REF_CLK       in   1   50 MHz clock; all logic on its rising edge
//  arst_n        in   1   asynchronous active-low reset
//  req0_valid    in   1   source 0 byte valid
//  req0_data     in   8   source 0 byte
//  req0_last     in   1   source 0 final byte of frame
//  req0_ready    out  1   source 0 byte accepted this cycle when valid&ready
//  req1_valid/req1_data/req1_last/req1_ready   same, source 1
//  fifo_din      out  8   byte to FIFO
//  fifo_wren     out  1   FIFO write strobe (combinational)
//  fifo_EOD_in   out  1   marks fifo_din as last byte of frame (qualified by fifo_wren)
//  fifo_full     in   1   FIFO cannot accept a write this cycle
//  busy          out  1   state != S_IDLE
//  grant         out  1   source being served (valid while busy)
//  frames_sent   out 16   binary count of frames completed (EOD written), wraps at 0xFFFF
//  trunc_count   out 16   binary count of frames truncated at MAX_LEN, wraps
// BEHAVIOUR
//  Reset (async, arst_n=0): state S_IDLE, grant=0, last_served=1, byte_cnt=0, crc=32'hFFFFFFFF,
//   counters=0; all outputs 0 (ready, wren, EOD, busy, din=8'h00). Async reset mid-frame
//   abandons the frame without EOD; the FIFO must be reset with it.
//  States: S_IDLE, S_BODY, S_PAD, S_FCS, S_DRAIN.
//  S_IDLE: if any reqN_valid, register grant (only one valid -> that one; both -> the one !=
//   last_served), clear byte_cnt, crc=FFFFFFFF, -> S_BODY. No byte accepted in S_IDLE, so the
//   first FIFO write occurs >=1 cycle after valid is first seen.
//  S_BODY: ready[grant] = ~fifo_full; ready of the other source is 0. On valid&ready:
//   fifo_wren=1, fifo_din=data, crc updated, byte_cnt++. On that transfer:
//   - last=1: -> S_PAD if byte_cnt+1 < MIN_LEN, else -> S_FCS.
//   - last=0 and byte_cnt+1 == MAX_LEN: trunc_count++, -> S_DRAIN.
//   fifo_full or ~valid: no write, state and crc hold (gaps inside a frame are allowed).
//  S_DRAIN: ready[grant]=1, bytes discarded (no wren, no crc update); on valid&last -> S_FCS.
//  S_PAD: each cycle with ~fifo_full write 8'h00 (crc updated), byte_cnt++; the write making
//   byte_cnt == MIN_LEN moves to S_FCS.
//  S_FCS: fcs = ~crc; write fcs[7:0], [15:8], [23:16], [31:24] in order, one per ~fifo_full
//   cycle; fifo_EOD_in=1 only with the 4th byte. After it: frames_sent++, last_served=grant,
//   -> S_IDLE. Never writes while fifo_full.
//  CRC: IEEE 802.3 reflected, poly 0xEDB88320, LSB-first per byte, init FFFFFFFF, over every
//   written body and pad byte; one byte per cycle combinational update.
//  byte_cnt 11 bits; saturation impossible (bounded by MAX_LEN). Counters wrap silently.
//  Inter-frame gap is the PHY interface's job; back-to-back frames may enter the FIFO with
//  one idle cycle between them (S_IDLE).
//  No output changes while fifo_full except ready (combinationally low).
// TESTING
//  T1 MIN_LEN=0: src0 sends ASCII "123456789" -> FIFO gets 31..39 then 26 39 F4 CB, EOD on CB.
//  T2 src1 sends 14-byte frame -> 14 bytes, 46x 00, 4 FCS = 64 writes; frames_sent=1.
//  T3 both valid from reset, 3 frames each queued -> grant order 0,1,0,1,0,1; no interleave.
//  T4 fifo_full pulsed 3 cycles mid-body and during FCS -> no writes while full, data intact,
//   FCS equal to unstalled run.
//  T5 MAX_LEN=16, 20-byte frame -> 16 bytes + FCS over 16, 4 source bytes consumed silently,
//   trunc_count=1, EOD once.
//  T6 arst_n low during byte 10 -> all outputs 0 same cycle; after release, new frame from
//   src0 granted first and written cleanly.

Source files
------------

// File: rtl/rmii_tx_frame_loader_if.sv
// rmii_tx_frame_loader_if: source handshakes and FIFO write port of the RMII TX frame loader
interface rmii_tx_frame_loader_if;
  logic       req0_valid;
  logic [7:0] req0_data;
  logic       req0_last;
  logic       req0_ready;
  logic       req1_valid;
  logic [7:0] req1_data;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] fifo_din;
  logic       fifo_wren;
  logic       fifo_EOD_in;
  logic       fifo_full;
  modport master (
    input  req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full,
    output req0_ready, req1_ready, fifo_din, fifo_wren, fifo_EOD_in
  );
  modport slave (
    output req0_valid, req0_data, req0_last, req1_valid, req1_data, req1_last, fifo_full,
    input  req0_ready, req1_ready, fifo_din, fifo_wren, fifo_EOD_in
  );
endinterface

// File: rtl/rmii_tx_frame_loader.sv
// rmii_tx_frame_loader: round-robin loader of two frame sources into the RMII TX FIFO, with
// zero padding to MIN_LEN, truncation at MAX_LEN and appended Ethernet FCS flagged by EOD.
module rmii_tx_frame_loader #(
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic                          REF_CLK,
  input  logic                          arst_n,
  rmii_tx_frame_loader_if.master        bus,
  output logic                          busy,
  output logic                          grant,
  output logic [15:0]                   frames_sent,
  output logic [15:0]                   trunc_count
);
  typedef enum logic [2:0] {S_IDLE, S_BODY, S_PAD, S_FCS, S_DRAIN} state_t;
  localparam logic [11:0] MIN_L = 12'(MIN_LEN);
  localparam logic [11:0] MAX_L = 12'(MAX_LEN);
  state_t      state, state_nx;
  logic        last_served;
  logic [10:0] byte_cnt;
  logic [11:0] cnt_inc;
  logic [31:0] crc, fcs;
  logic [1:0]  fcs_idx;
  logic        any_valid, sel_valid, sel_last, body_wr, pad_wr, fcs_wr, fcs_done, trunc, rdy;
  logic [7:0]  sel_data;

  // reflected CRC-32, data bits consumed LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    sel_valid = grant ? bus.req1_valid : bus.req0_valid;
    sel_data  = grant ? bus.req1_data : bus.req0_data;
    sel_last  = grant ? bus.req1_last : bus.req0_last;
    cnt_inc   = {1'b0, byte_cnt} + 12'd1;
    fcs       = ~crc;
    body_wr   = state == S_BODY && sel_valid && !bus.fifo_full;
    pad_wr    = state == S_PAD && !bus.fifo_full;
    fcs_wr    = state == S_FCS && !bus.fifo_full;
    fcs_done  = fcs_wr && fcs_idx == 2'd3;
    trunc     = body_wr && !sel_last && cnt_inc == MAX_L;
  end

  always_ff @(posedge REF_CLK or negedge arst_n)
    if (!arst_n) state <= S_IDLE;
    else state <= state_nx;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  state_nx = any_valid ? S_BODY : S_IDLE;
      S_BODY:  if (body_wr) state_nx = sel_last ? (cnt_inc < MIN_L ? S_PAD : S_FCS) : (trunc ? S_DRAIN : S_BODY);
      S_PAD:   if (pad_wr && cnt_inc >= MIN_L) state_nx = S_FCS;
      S_DRAIN: if (sel_valid && sel_last) state_nx = S_FCS;
      S_FCS:   if (fcs_done) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // din follows the state rather than the strobe so it holds steady while the FIFO is full
  always_comb begin
    rdy             = (state == S_BODY && !bus.fifo_full) || state == S_DRAIN;
    bus.req0_ready  = rdy && !grant;
    bus.req1_ready  = rdy && grant;
    bus.fifo_wren   = body_wr || pad_wr || fcs_wr;
    bus.fifo_din    = state == S_BODY ? sel_data : state == S_FCS ? fcs[{fcs_idx, 3'b000} +: 8] : 8'h00;
    bus.fifo_EOD_in = fcs_done;
    busy            = state != S_IDLE;
  end

  always_ff @(posedge REF_CLK or negedge arst_n)
    if (!arst_n) begin
      grant       <= 1'b0;
      last_served <= 1'b1;
      byte_cnt    <= '0;
      crc         <= 32'hFFFFFFFF;
      fcs_idx     <= '0;
      frames_sent <= '0;
      trunc_count <= '0;
    end else begin
      if (state == S_IDLE && any_valid) begin
        grant    <= (bus.req0_valid && bus.req1_valid) ? ~last_served : bus.req1_valid;
        byte_cnt <= '0;
        crc      <= 32'hFFFFFFFF;
        fcs_idx  <= '0;
      end
      if (body_wr || pad_wr) begin
        crc      <= crc_byte(crc, body_wr ? sel_data : 8'h00);
        byte_cnt <= cnt_inc[10:0];
      end
      if (trunc) trunc_count <= trunc_count + 16'd1;
      if (fcs_wr) fcs_idx <= fcs_idx + 2'd1;
      if (fcs_done) begin
        frames_sent <= frames_sent + 16'd1;
        last_served <= grant;
      end
    end
endmodule

// File: tb/tb_rmii_tx_frame_loader.sv
// tb_rmii_tx_frame_loader: directed vectors against two loader configurations
// (a: MIN_LEN=0/MAX_LEN=16, b: defaults) with queue-fed sources and a FIFO write monitor.
module tb_rmii_tx_frame_loader;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #10 clk = ~clk;

  rmii_tx_frame_loader_if ia ();
  rmii_tx_frame_loader_if ib ();
  logic        busy_a, busy_b, grant_a, grant_b;
  logic [15:0] fs_a, fs_b, tc_a, tc_b;

  rmii_tx_frame_loader #(.MIN_LEN(0), .MAX_LEN(16)) dut_a (
    .REF_CLK(clk), .arst_n(arst_n), .bus(ia), .busy(busy_a), .grant(grant_a),
    .frames_sent(fs_a), .trunc_count(tc_a));
  rmii_tx_frame_loader dut_b (
    .REF_CLK(clk), .arst_n(arst_n), .bus(ib), .busy(busy_b), .grant(grant_b),
    .frames_sent(fs_b), .trunc_count(tc_b));

  // sources 0,1 feed dut_a, sources 2,3 feed dut_b
  logic       vld [4];
  logic [7:0] dat [4];
  logic       lst [4];
  logic       rdy [4];
  logic       full [2];
  logic [8:0] sq [4][$];
  logic [9:0] cap [2][$];
  int         ecnt [2];
  int         nvec, nfail;

  assign ia.req0_valid = vld[0];
  assign ia.req0_data  = dat[0];
  assign ia.req0_last  = lst[0];
  assign ia.req1_valid = vld[1];
  assign ia.req1_data  = dat[1];
  assign ia.req1_last  = lst[1];
  assign ib.req0_valid = vld[2];
  assign ib.req0_data  = dat[2];
  assign ib.req0_last  = lst[2];
  assign ib.req1_valid = vld[3];
  assign ib.req1_data  = dat[3];
  assign ib.req1_last  = lst[3];
  assign ia.fifo_full  = full[0];
  assign ib.fifo_full  = full[1];
  assign rdy[0] = ia.req0_ready;
  assign rdy[1] = ia.req1_ready;
  assign rdy[2] = ib.req0_ready;
  assign rdy[3] = ib.req1_ready;

  initial begin : drv
    logic fire [4];
    for (int s = 0; s < 4; s++) begin
      vld[s] = 1'b0;
      dat[s] = 8'h00;
      lst[s] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int s = 0; s < 4; s++) fire[s] = vld[s] && rdy[s];
      @(posedge clk);
      #1;
      for (int s = 0; s < 4; s++) begin
        if (fire[s] && sq[s].size() > 0) void'(sq[s].pop_front());
        vld[s] = sq[s].size() > 0;
        {lst[s], dat[s]} = vld[s] ? sq[s][0] : 9'h000;
      end
    end
  end

  initial begin : mon
    forever begin
      @(negedge clk);
      if (ia.fifo_wren) begin
        cap[0].push_back({grant_a, ia.fifo_EOD_in, ia.fifo_din});
        if (ia.fifo_EOD_in) ecnt[0]++;
      end
      if (ib.fifo_wren) begin
        cap[1].push_back({grant_b, ib.fifo_EOD_in, ib.fifo_din});
        if (ib.fifo_EOD_in) ecnt[1]++;
      end
    end
  end

  initial begin
    #(20 * 40000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int seed, input int k);
    return 8'(seed * 31 + k * 7 + (k >> 3));
  endfunction

  function automatic logic [31:0] crc32(input logic [7:0] b[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (b[i]) begin
      c ^= {24'h0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic send(input int q, input int len, input int seed);
    for (int k = 0; k < len; k++) sq[q].push_back({k == len - 1, gen(seed, k)});
  endtask

  task automatic wait_eod(input int d, input int tgt, input string tag);
    int t;
    t = 0;
    while (ecnt[d] < tgt && t < 5000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({tag, " eod_seen"}, 32'(ecnt[d] >= tgt), 1);
  endtask

  task automatic wait_cap(input int d, input int n, input string tag);
    int t;
    t = 0;
    while (cap[d].size() < n && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk({tag, " progress"}, 32'(cap[d].size() >= n), 1);
  endtask

  task automatic cmp_frame(input int d, input logic [7:0] e[$], input logic g, input string tag);
    int bad, eods, gbad;
    logic [9:0] w;
    chk({tag, " avail"}, 32'(cap[d].size() >= e.size()), 1);
    if (cap[d].size() < e.size()) return;
    bad = 0;
    eods = 0;
    gbad = 0;
    foreach (e[i]) begin
      w = cap[d].pop_front();
      if (w[7:0] !== e[i]) bad++;
      if (w[8] !== (i == e.size() - 1)) eods++;
      if (w[9] !== g) gbad++;
    end
    chk({tag, " bad_bytes"}, 32'(bad), 0);
    chk({tag, " bad_eod"}, 32'(eods), 0);
    chk({tag, " bad_grant"}, 32'(gbad), 0);
  endtask

  task automatic check_frame(input int d, input int len, input int seed, input logic g, input string tag);
    logic [7:0] e[$];
    logic [31:0] c;
    int minl, maxl, nb;
    minl = d == 0 ? 0 : 60;
    maxl = d == 0 ? 16 : 1514;
    nb = len > maxl ? maxl : len;
    for (int k = 0; k < nb; k++) e.push_back(gen(seed, k));
    while (e.size() < minl) e.push_back(8'h00);
    c = crc32(e);
    for (int k = 0; k < 4; k++) e.push_back(c[8*k +: 8]);
    cmp_frame(d, e, g, tag);
  endtask

  typedef struct {
    int d;
    int s;
    int len;
    int seed;
    int exp_writes;
    int exp_trunc;
  } vec_t;

  initial begin
    vec_t tv [9];
    logic [7:0] e1[$];
    int ef [2];
    int q, tgt;
    tv[0] = '{1, 1, 14, 1, 64, 0};
    tv[1] = '{0, 1, 5, 2, 9, 0};
    tv[2] = '{0, 0, 16, 3, 20, 0};
    tv[3] = '{0, 1, 20, 4, 20, 1};
    tv[4] = '{1, 0, 60, 5, 64, 0};
    tv[5] = '{1, 0, 1, 6, 64, 0};
    tv[6] = '{1, 1, 61, 7, 65, 0};
    tv[7] = '{0, 0, 17, 8, 20, 2};
    tv[8] = '{0, 1, 1, 9, 5, 2};
    ef[0] = 0;
    ef[1] = 0;
    full[0] = 1'b0;
    full[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst wren", {31'h0, ib.fifo_wren}, 0);
    chk("rst busy", {31'h0, busy_b}, 0);
    chk("rst din", {24'h0, ib.fifo_din}, 0);
    chk("rst frames", {16'h0, fs_a}, 0);
    @(posedge clk);
    #1 arst_n = 1'b1;
    // "123456789" with no padding: FCS bytes are the well known check value CBF43926
    for (int k = 0; k < 9; k++) sq[0].push_back({k == 8, 8'(8'h31 + k)});
    for (int k = 0; k < 9; k++) e1.push_back(8'(8'h31 + k));
    e1.push_back(8'h26);
    e1.push_back(8'h39);
    e1.push_back(8'hF4);
    e1.push_back(8'hCB);
    wait_eod(0, 1, "t1");
    repeat (2) @(negedge clk);
    chk("t1 writes", 32'(cap[0].size()), 13);
    cmp_frame(0, e1, 1'b0, "t1");
    ef[0]++;
    chk("t1 frames", {16'h0, fs_a}, 32'(ef[0]));
    for (int i = 0; i < 9; i++) begin
      q = tv[i].d * 2 + tv[i].s;
      tgt = ecnt[tv[i].d] + 1;
      send(q, tv[i].len, tv[i].seed);
      wait_eod(tv[i].d, tgt, $sformatf("v%0d", i));
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d writes", i), 32'(cap[tv[i].d].size()), 32'(tv[i].exp_writes));
      ef[tv[i].d]++;
      chk($sformatf("v%0d frames", i), {16'h0, tv[i].d == 0 ? fs_a : fs_b}, 32'(ef[tv[i].d]));
      chk($sformatf("v%0d trunc", i), {16'h0, tv[i].d == 0 ? tc_a : tc_b}, 32'(tv[i].exp_trunc));
      chk($sformatf("v%0d src_drained", i), 32'(sq[q].size()), 0);
      check_frame(tv[i].d, tv[i].len, tv[i].seed, tv[i].s[0], $sformatf("v%0d", i));
    end
    // fresh reset, then both sources of dut_b loaded with three frames each
    @(posedge clk);
    #1 arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    chk("t3 rst frames", {16'h0, fs_b}, 0);
    chk("t3 rst trunc", {16'h0, tc_a}, 0);
    send(2, 10, 20);
    send(2, 70, 21);
    send(2, 20, 22);
    send(3, 64, 30);
    send(3, 5, 31);
    send(3, 30, 32);
    wait_eod(1, ecnt[1] + 6, "t3");
    repeat (2) @(negedge clk);
    chk("t3 frames", {16'h0, fs_b}, 6);
    check_frame(1, 10, 20, 1'b0, "t3 f0");
    check_frame(1, 64, 30, 1'b1, "t3 f1");
    check_frame(1, 70, 21, 1'b0, "t3 f2");
    check_frame(1, 5, 31, 1'b1, "t3 f3");
    check_frame(1, 20, 22, 1'b0, "t3 f4");
    check_frame(1, 30, 32, 1'b1, "t3 f5");
    // stall the FIFO mid-body and mid-FCS
    tgt = ecnt[1] + 1;
    send(2, 20, 40);
    wait_cap(1, 8, "t4 body");
    @(posedge clk);
    #1 full[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4 wren_body_full", {31'h0, ib.fifo_wren}, 0);
      chk("t4 ready_full", {31'h0, rdy[2]}, 0);
    end
    @(posedge clk);
    #1 full[1] = 1'b0;
    wait_cap(1, 61, "t4 fcs");
    @(posedge clk);
    #1 full[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t4 wren_fcs_full", {31'h0, ib.fifo_wren}, 0);
    end
    @(posedge clk);
    #1 full[1] = 1'b0;
    wait_eod(1, tgt, "t4");
    repeat (2) @(negedge clk);
    chk("t4 writes", 32'(cap[1].size()), 64);
    check_frame(1, 20, 40, 1'b0, "t4");
    chk("t4 frames", {16'h0, fs_b}, 7);
    // asynchronous reset in the middle of a frame
    send(2, 30, 50);
    wait_cap(1, 10, "t6");
    #1 arst_n = 1'b0;
    #1;
    chk("t6 wren", {31'h0, ib.fifo_wren}, 0);
    chk("t6 eod", {31'h0, ib.fifo_EOD_in}, 0);
    chk("t6 busy", {31'h0, busy_b}, 0);
    chk("t6 din", {24'h0, ib.fifo_din}, 0);
    chk("t6 ready", {30'h0, rdy[2], rdy[3]}, 0);
    chk("t6 frames", {16'h0, fs_b}, 0);
    sq[2].delete();
    cap[1].delete();
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    tgt = ecnt[1] + 2;
    send(3, 12, 61);
    send(2, 8, 60);
    wait_eod(1, tgt, "t6 post");
    repeat (2) @(negedge clk);
    check_frame(1, 8, 60, 1'b0, "t6 p0");
    check_frame(1, 12, 61, 1'b1, "t6 p1");
    chk("t6 post frames", {16'h0, fs_b}, 2);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
